// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 port arbiter between the I-side and D-side L1 miss paths.
package l2_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SERVE_I,
        S_SERVE_D,
        S_RETURN
    } l2_arb_state_e;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_e;

endpackage

// File: rtl/l2_arbiter_if.sv
// Bundle of the two L1 requester handshakes and the L2 CPU-side port seen by the arbiter.
interface l2_arbiter_if;
    import l2_arb_pkg::*;

    addr_t i_addr;
    logic  i_read;
    logic  i_resp;
    line_t i_rdata;

    addr_t d_addr;
    logic  d_read;
    logic  d_write;
    line_t d_wdata;
    logic  d_resp;
    line_t d_rdata;

    addr_t l2_addr;
    logic  l2_read;
    logic  l2_write;
    line_t l2_wdata;
    line_t l2_rdata;
    logic  l2_resp;

    // Arbiter view
    modport slave (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, l2_rdata, l2_resp,
        output i_resp, i_rdata, d_resp, d_rdata, l2_addr, l2_read, l2_write, l2_wdata
    );

    // Environment view: L1 controllers plus the L2 cache
    modport master (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata, l2_rdata, l2_resp,
        input  i_resp, i_rdata, d_resp, d_rdata, l2_addr, l2_read, l2_write, l2_wdata
    );

endinterface

// File: rtl/l2_arb_rr_picker.sv
// Two-input round-robin picker; on contention the side that did not win last time is chosen.
module l2_arb_rr_picker
    import l2_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  grant_e last_grant,
    output logic   grant_valid,
    output grant_e grant
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant       = GRANT_I;
        if (i_req && d_req) begin
            grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_req) begin
            grant = GRANT_D;
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 CPU-side port between the I-side and D-side L1 miss paths.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    l2_arbiter_if.slave bus,
    output logic       busy,
    output logic       timeout_err
);

    localparam int unsigned       CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    l2_arb_state_e    state;
    l2_arb_state_e    state_nx;
    grant_e           last_grant;
    grant_e           grant;
    logic             grant_valid;
    logic [CNT_W-1:0] wait_cnt;

    addr_t l2_addr_q;
    logic  l2_read_q;
    logic  l2_write_q;
    line_t l2_wdata_q;
    line_t rdata_q;

    l2_arb_rr_picker picker (
        .i_req       (bus.i_read),
        .d_req       (bus.d_read | bus.d_write),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:               if (grant_valid) state_nx = (grant == GRANT_I) ? S_SERVE_I : S_SERVE_D;
            S_SERVE_I, S_SERVE_D: if (bus.l2_resp) state_nx = S_RETURN;
            S_RETURN:             state_nx = S_IDLE;
            default:              state_nx = S_IDLE;
        endcase
    end

    // last_grant doubles as the record of which side is being served
    always_comb begin
        busy        = (state != S_IDLE);
        bus.i_resp  = 1'b0;
        bus.d_resp  = 1'b0;
        bus.i_rdata = '0;
        bus.d_rdata = '0;
        if (state == S_RETURN) begin
            if (last_grant == GRANT_I) begin
                bus.i_resp  = 1'b1;
                bus.i_rdata = rdata_q;
            end else begin
                bus.d_resp  = 1'b1;
                bus.d_rdata = rdata_q;
            end
        end
    end

    // Holding registers drive the L2 port; a simultaneous D read+write is issued as a write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l2_addr_q   <= '0;
            l2_read_q   <= 1'b0;
            l2_write_q  <= 1'b0;
            l2_wdata_q  <= '0;
            rdata_q     <= '0;
            last_grant  <= GRANT_D;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        last_grant <= grant;
                        wait_cnt   <= '0;
                        if (grant == GRANT_I) begin
                            l2_addr_q  <= bus.i_addr;
                            l2_read_q  <= 1'b1;
                            l2_write_q <= 1'b0;
                            l2_wdata_q <= '0;
                        end else begin
                            l2_addr_q  <= bus.d_addr;
                            l2_read_q  <= ~bus.d_write;
                            l2_write_q <= bus.d_write;
                            l2_wdata_q <= bus.d_write ? bus.d_wdata : '0;
                        end
                    end
                end
                S_SERVE_I, S_SERVE_D: begin
                    if (bus.l2_resp) begin
                        rdata_q    <= bus.l2_rdata;
                        l2_addr_q  <= '0;
                        l2_read_q  <= 1'b0;
                        l2_write_q <= 1'b0;
                        l2_wdata_q <= '0;
                        wait_cnt   <= '0;
                    end else if (wait_cnt == CNT_MAX) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.l2_addr  = l2_addr_q;
    assign bus.l2_read  = l2_read_q;
    assign bus.l2_write = l2_write_q;
    assign bus.l2_wdata = l2_wdata_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: contention order, lone requests, latching, stray resp, timeout, reset.
module tb_l2_arbiter;
    import l2_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic timeout_err;
    int   total = 0;
    int   bad   = 0;

    l2_arbiter_if bus ();

    l2_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input line_t got, input line_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle with requests already applied; L2 answers in serve cycle 'lat'.
    task automatic txn(input string tag, input bit side_i, input addr_t a, input bit wr,
                       input line_t wd, input int lat, input line_t rd, input bit drop,
                       input addr_t d_addr_mid);
        step();
        chk({tag, ".busy"},  line_t'(busy), 1);
        chk({tag, ".rd"},    line_t'(bus.l2_read), line_t'(!wr));
        chk({tag, ".wr"},    line_t'(bus.l2_write), line_t'(wr));
        chk({tag, ".addr"},  line_t'(bus.l2_addr), line_t'(a));
        chk({tag, ".wdata"}, bus.l2_wdata, wd);
        bus.d_addr = d_addr_mid;
        for (int c = 1; c < lat; c++) begin
            step();
            chk({tag, ".hold_addr"}, line_t'(bus.l2_addr), line_t'(a));
            chk({tag, ".no_resp"},   line_t'({bus.i_resp, bus.d_resp}), 0);
        end
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = rd;
        step();
        bus.l2_resp  = 1'b0;
        bus.l2_rdata = '0;
        chk({tag, ".ret_rdwr"}, line_t'({bus.l2_read, bus.l2_write}), 0);
        chk({tag, ".i_resp"},   line_t'(bus.i_resp), line_t'(side_i));
        chk({tag, ".d_resp"},   line_t'(bus.d_resp), line_t'(!side_i));
        chk({tag, ".i_rdata"},  bus.i_rdata, side_i ? rd : '0);
        chk({tag, ".d_rdata"},  bus.d_rdata, side_i ? '0 : rd);
        if (drop) begin
            bus.i_read  = 1'b0;
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
        end
        step();
        chk({tag, ".idle_busy"}, line_t'(busy), 0);
        chk({tag, ".idle_rdwr"}, line_t'({bus.l2_read, bus.l2_write}), 0);
        chk({tag, ".idle_resp"}, line_t'({bus.i_resp, bus.d_resp}), 0);
    endtask

    initial begin
        line_t dead;
        line_t wd2;
        dead = {8{32'hDEADBEEF}};
        wd2  = {16{16'h1234}};
        bus.i_addr   = '0;
        bus.i_read   = 1'b0;
        bus.d_addr   = '0;
        bus.d_read   = 1'b0;
        bus.d_write  = 1'b0;
        bus.d_wdata  = '0;
        bus.l2_rdata = '0;
        bus.l2_resp  = 1'b0;

        step();
        step();
        chk("rst.busy",  line_t'(busy), 0);
        chk("rst.rdwr",  line_t'({bus.l2_read, bus.l2_write}), 0);
        chk("rst.addr",  line_t'(bus.l2_addr), 0);
        chk("rst.resp",  line_t'({bus.i_resp, bus.d_resp}), 0);
        chk("rst.terr",  line_t'(timeout_err), 0);
        rst = 1'b1;
        step();
        chk("post_rst.busy", line_t'(busy), 0);

        // Continuous contention: I, D, I, D with one idle cycle between
        bus.i_addr  = 32'h0000_2000;
        bus.i_read  = 1'b1;
        bus.d_addr  = 32'h0000_3000;
        bus.d_write = 1'b1;
        bus.d_wdata = dead;
        txn("c0", 1'b1, 32'h2000, 1'b0, '0,   1, {32{8'h11}}, 1'b0, 32'h3000);
        txn("c1", 1'b0, 32'h3000, 1'b1, dead, 1, {32{8'h22}}, 1'b0, 32'h3000);
        txn("c2", 1'b1, 32'h2000, 1'b0, '0,   2, {32{8'h33}}, 1'b0, 32'h3000);
        txn("c3", 1'b0, 32'h3000, 1'b1, dead, 2, {32{8'h44}}, 1'b1, 32'h3000);

        // Lone I read with L2 answering in serve cycle 5
        bus.i_addr = 32'h0000_1000;
        bus.i_read = 1'b1;
        txn("li", 1'b1, 32'h1000, 1'b0, '0, 5, {32{8'hA5}}, 1'b1, 32'h3000);

        // D address changes mid-serve; latched copy stays on the port
        bus.d_addr = 32'h0000_4000;
        bus.d_read = 1'b1;
        txn("ac", 1'b0, 32'h4000, 1'b0, '0, 3, {32{8'h5A}}, 1'b1, 32'h5000);

        // Stray resp while idle is ignored
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = '1;
        step();
        bus.l2_resp  = 1'b0;
        bus.l2_rdata = '0;
        chk("stray.busy", line_t'(busy), 0);
        chk("stray.resp", line_t'({bus.i_resp, bus.d_resp}), 0);
        step();
        chk("stray.busy2", line_t'(busy), 0);
        chk("stray.resp2", line_t'({bus.i_resp, bus.d_resp}), 0);

        // Illegal read+write issues a write
        bus.d_addr  = 32'h0000_7000;
        bus.d_read  = 1'b1;
        bus.d_write = 1'b1;
        bus.d_wdata = wd2;
        txn("rw", 1'b0, 32'h7000, 1'b1, wd2, 2, {32{8'h77}}, 1'b1, 32'h7000);

        // Timeout: error after 8 serve cycles, late resp still completes
        bus.i_addr = 32'h0000_6000;
        bus.i_read = 1'b1;
        step();
        for (int c = 1; c <= 8; c++) begin
            chk("to.pre", line_t'(timeout_err), 0);
            step();
        end
        for (int c = 9; c <= 11; c++) begin
            chk("to.err",  line_t'(timeout_err), 1);
            chk("to.busy", line_t'(busy), 1);
            chk("to.rd",   line_t'(bus.l2_read), 1);
            if (c < 11) step();
        end
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = {32{8'hC3}};
        step();
        bus.l2_resp  = 1'b0;
        bus.i_read   = 1'b0;
        chk("to.i_resp",  line_t'(bus.i_resp), 1);
        chk("to.i_rdata", bus.i_rdata, {32{8'hC3}});
        chk("to.err_ret", line_t'(timeout_err), 1);
        step();
        chk("to.idle",     line_t'(busy), 0);
        chk("to.err_idle", line_t'(timeout_err), 1);

        // Async reset in the middle of a D write
        bus.d_addr  = 32'h0000_8000;
        bus.d_write = 1'b1;
        bus.d_wdata = dead;
        step();
        chk("rs.wr_before", line_t'(bus.l2_write), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rs.wr",   line_t'(bus.l2_write), 0);
        chk("rs.busy", line_t'(busy), 0);
        chk("rs.terr", line_t'(timeout_err), 0);
        bus.i_addr = 32'h0000_9000;
        bus.i_read = 1'b1;
        step();
        rst = 1'b1;
        txn("rsI", 1'b1, 32'h9000, 1'b0, '0,   2, {32{8'h99}}, 1'b0, 32'h8000);
        txn("rsD", 1'b0, 32'h8000, 1'b1, dead, 2, {32{8'h88}}, 1'b1, 32'h8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Shares the single L2 cache CPU-side port between the I-side and D-side L1 miss paths.
- Each requester uses the L2-style level handshake: hold read/write until a one-cycle resp.
- Latches the winner's request, drives the L2 port from registers, returns line data, and alternates priority on contention.
- Sits between both L1 controllers and the L2 cache control/datapath.

Parameters:
- ADDR_W, 32, address width (line-aligned addresses).
- LINE_W, 256, cache line width in bits.
- TIMEOUT_CYCLES, 1024, L2 wait cycles before timeout_err sets (minimum 2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- i_addr  in  ADDR_W  I-side line address.
- i_read  in  1  I-side read request (level).
- i_resp  out  1  I-side one-cycle completion.
- i_rdata  out  LINE_W  line returned to I-side; valid when i_resp=1.
- d_addr  in  ADDR_W  D-side line address.
- d_read  in  1  D-side read request.
- d_write  in  1  D-side write request.
- d_wdata  in  LINE_W  D-side write line.
- d_resp  out  1  D-side one-cycle completion.
- d_rdata  out  LINE_W  line returned to D-side; valid when d_resp=1.
- l2_addr  out  ADDR_W  to L2, registered.
- l2_read  out  1  to L2, registered.
- l2_write  out  1  to L2, registered.
- l2_wdata  out  LINE_W  to L2, registered.
- l2_rdata  in  LINE_W  from L2.
- l2_resp  in  1  from L2, one-cycle.
- busy  out  1  state != S_IDLE.
- timeout_err  out  1  sticky; set on L2 timeout.

Behaviour:
- Reset (rst=0, async): state=S_IDLE; all outputs 0; holding regs 0; wait counter 0; last_grant=D, so I wins the first contention.
- States: S_IDLE, S_SERVE_I, S_SERVE_D, S_RETURN.
- S_IDLE arbitration:
  - i_req = i_read. d_req = d_read | d_write.
  - Only one side requesting: that side is granted.
  - Both requesting: grant the side != last_grant.
  - On grant: capture addr, op, and wdata (D write only) into holding regs; set last_grant; go to S_SERVE_I or S_SERVE_D.
  - l2_read/l2_write rise in the first SERVE cycle, since they are registered.
- D op encoding: d_read & d_write together is illegal; write wins. A D read drives l2_wdata=0.
- S_SERVE_x:
  - Hold l2_* constant; the wait counter increments each cycle.
  - On l2_resp=1: capture l2_rdata into rdata_q, clear l2_read/l2_write and the counter, go to S_RETURN.
  - The L2 sees the request drop in the cycle after its resp, as its controller requires.
- S_RETURN (exactly 1 cycle):
  - Assert the served side's resp with x_rdata=rdata_q; l2_* stay 0; next state S_IDLE.
  - The requester must drop its request the cycle after resp.
  - No arbitration occurs in S_RETURN, so the minimum gap between L2 transactions is 1 idle cycle.
- Latency: requester resp = 1 cycle after l2_resp. Minimum end-to-end latency = 3 cycles plus the L2 latency.
- Unserved resp/rdata outputs are 0.
- A requester changing addr/wdata while waiting has no effect; the latched copy is used.
- Timeout:
  - Counter saturates at TIMEOUT_CYCLES-1; on reaching it, timeout_err=1 (sticky until reset).
  - The transaction is not aborted; it keeps waiting for l2_resp.
- l2_resp in S_IDLE or S_RETURN is ignored.
- Fairness: under continuous contention, grants strictly alternate I,D,I,D.
- A lone requester may be granted back-to-back.

Decomposition:
- Package l2_arb_pkg:
  - state enum (l2_arb_state_e).
  - grant enum (GRANT_I, GRANT_D).
  - line_t, addr_t typedefs.
  - constants LINE_W=256, ADDR_W=32.
- Sub-module l2_arb_rr_picker: 2-input round-robin picker.
  - Inputs: i_req, d_req, last_grant.
  - Outputs: grant_valid, grant.
  - Combinational; last_grant is held in l2_arbiter.

Test Plan:
- Reset mid-S_SERVE_D with l2_write=1: rst low -> same cycle l2_write=0, busy=0, state S_IDLE; the next contention grants I first.
- Lone I read, addr 0x0000_1000, L2 resp after 5 cycles, rdata=0xA5 repeated:
  - l2_read=1 with addr 0x1000 from cycle 1.
  - l2_resp in cycle 5, so l2_read=0 in cycle 6 and i_resp=1 with i_rdata=0xA5.. in cycle 6.
  - d_resp stays 0 throughout.
- Simultaneous i_read (0x2000) and d_write (0x3000, wdata=0xDEAD..) held continuously:
  - Grants are I, D, I, D.
  - The D transaction shows l2_write=1, l2_addr=0x3000, l2_wdata=0xDEAD...
  - Exactly 1 idle cycle with l2_read=l2_write=0 between transactions.
- D-side changes d_addr 0x4000 -> 0x5000 mid-serve: l2_addr stays 0x4000 until l2_resp.
- TIMEOUT_CYCLES=8, L2 never responds:
  - timeout_err=1 after 8 SERVE cycles; busy=1; l2_read held.
  - A late l2_resp completes normally with timeout_err still 1.
- d_read=d_write=1 and a stray l2_resp in S_IDLE:
  - The D request is issued as a write.
  - The stray resp causes no state change and no resp pulse.
